ita_output_writer: RTL



---
 rtl/ita_output_writer_pkg.sv | 28 ++
 rtl/ita_output_writer_if.sv | 27 ++
 rtl/ita_output_writer_addr_gen.sv | 66 ++++++
 rtl/ita_output_writer.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/ita_output_writer_pkg.sv
`default_nettype none
// ita_package: shared lane/tile constants, widths and writer FSM states.
package ita_package;
  localparam int N      = 16;
  localparam int M      = 64;
  localparam int ADDR_W = 32;
  localparam int DIM_W  = 16;
  localparam int LOG_N  = $clog2(N);
  localparam int LOG_M  = $clog2(M);
  localparam int BEATS  = M * M / N;
  localparam int CNT_W  = $clog2(BEATS);

  typedef logic [N*8-1:0] oup_beat_t;

  typedef enum logic [1:0] {
    Idle  = 2'd0,
    Run   = 2'd1,
    Drain = 2'd2
  } writer_state_e;

  // ceil(dim / M), evaluated one bit wider so a near-full dimension cannot overflow
  function automatic logic [DIM_W-1:0] tile_count(input logic [DIM_W-1:0] dim);
    logic [DIM_W:0] sum;
    sum = {1'b0, dim} + (DIM_W+1)'(M - 1);
    return DIM_W'(sum >> LOG_M);
  endfunction
endpackage
`default_nettype wire

// File: rtl/ita_output_writer_if.sv
`default_nettype none
// ita_output_writer_if: result-stream handshake plus memory write port.
interface ita_output_writer_if;
  import ita_package::*;

  logic              oup_valid;
  logic              oup_ready;
  oup_beat_t         oup_data;
  logic              mem_req;
  logic              mem_gnt;
  logic [ADDR_W-1:0] mem_addr;
  oup_beat_t         mem_wdata;
  logic [N-1:0]      mem_be;

  // writer side
  modport slave (
    input  oup_valid, oup_data, mem_gnt,
    output oup_ready, mem_req, mem_addr, mem_wdata, mem_be
  );

  // stream source / memory side
  modport master (
    output oup_valid, oup_data, mem_gnt,
    input  oup_ready, mem_req, mem_addr, mem_wdata, mem_be
  );
endinterface
`default_nettype wire

// File: rtl/ita_output_writer_addr_gen.sv
`default_nettype none
// ita_out_addr_gen: walks M x M output tiles (tile_x fastest) and derives
// the row-major byte address, padding flag and lane byte enables per beat.
module ita_out_addr_gen
  import ita_package::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              advance,
  input  logic [DIM_W-1:0]  seq_length,
  input  logic [DIM_W-1:0]  out_cols,
  input  logic [DIM_W-1:0]  row_stride,
  input  logic [DIM_W-1:0]  tiles_x,
  input  logic [DIM_W-1:0]  tiles_y,
  input  logic [ADDR_W-1:0] base_addr,
  output logic              padded,
  output logic              last,
  output logic [N-1:0]      be,
  output logic [ADDR_W-1:0] addr
);
  logic [CNT_W-1:0]  count;
  logic [DIM_W-1:0]  tile_x;
  logic [DIM_W-1:0]  tile_y;
  logic [ADDR_W-1:0] row;
  logic [ADDR_W-1:0] col;
  logic              tile_end;
  logic              x_end;

  assign tile_end = (count == '1);
  assign x_end    = (tile_x == tiles_x - DIM_W'(1));

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count  <= '0;
      tile_x <= '0;
      tile_y <= '0;
    end else if (advance) begin
      count <= count + CNT_W'(1);
      if (tile_end) begin
        if (x_end) begin
          tile_x <= '0;
          tile_y <= tile_y + DIM_W'(1);
        end else begin
          tile_x <= tile_x + DIM_W'(1);
        end
      end
    end
  end

  // low count bits step down the rows of a tile, high bits pick the N-lane column group
  assign row = ADDR_W'(count[LOG_M-1:0]) + (ADDR_W'(tile_y) << LOG_M);
  assign col = (ADDR_W'(count[CNT_W-1:LOG_M]) << LOG_N) + (ADDR_W'(tile_x) << LOG_M);

  assign padded = (row >= ADDR_W'(seq_length)) || (col >= ADDR_W'(out_cols));
  assign last   = tile_end && x_end && (tile_y == tiles_y - DIM_W'(1));
  assign addr   = base_addr + row * ADDR_W'(row_stride) + col;

  always_comb begin
    be = '0;
    for (int i = 0; i < N; i++) begin
      be[i] = (col + ADDR_W'(i)) < ADDR_W'(out_cols);
    end
  end
endmodule
`default_nettype wire

// File: rtl/ita_output_writer.sv
`default_nettype none
// ita_output_writer: drains result beats into memory at row-major addresses.
// Optional ITA_OUT_WRITER_STATS_EN adds write/drop/stall counters.
module ita_output_writer
  import ita_package::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DIM_W-1:0]  seq_length,
  input  logic [DIM_W-1:0]  out_cols,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [DIM_W-1:0]  row_stride,
  ita_output_writer_if.slave bus,
  output logic              busy,
  output logic              done,
  output logic [31:0]       stat_wr,
  output logic [31:0]       stat_drop,
  output logic [31:0]       stat_stall
);
  writer_state_e     state;
  logic [DIM_W-1:0]  cfg_seq, cfg_cols, cfg_stride, cfg_tx, cfg_ty;
  logic [ADDR_W-1:0] cfg_base;
  logic              req;
  logic [ADDR_W-1:0] addr_q;
  oup_beat_t         wdata_q;
  logic [N-1:0]      be_q;
  logic              gen_padded, gen_last;
  logic [N-1:0]      gen_be;
  logic [ADDR_W-1:0] gen_addr;
  logic              idle, slot_free, ready, accept;

  assign idle      = (state == Idle);
  assign slot_free = !req || bus.mem_gnt;
  assign ready     = (state == Run) && (slot_free || gen_padded);
  assign accept    = ready && bus.oup_valid;

  assign bus.oup_ready = ready;
  assign bus.mem_req   = req;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.mem_be    = be_q;

  ita_out_addr_gen u_addr_gen (
    .clk        (clk),
    .rst        (rst),
    .clear      (idle),
    .advance    (accept),
    .seq_length (cfg_seq),
    .out_cols   (cfg_cols),
    .row_stride (cfg_stride),
    .tiles_x    (cfg_tx),
    .tiles_y    (cfg_ty),
    .base_addr  (cfg_base),
    .padded     (gen_padded),
    .last       (gen_last),
    .be         (gen_be),
    .addr       (gen_addr)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= Idle;
      busy       <= 1'b0;
      done       <= 1'b0;
      req        <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      be_q       <= '0;
      cfg_seq    <= '0;
      cfg_cols   <= '0;
      cfg_stride <= '0;
      cfg_tx     <= '0;
      cfg_ty     <= '0;
      cfg_base   <= '0;
    end else begin
      done <= 1'b0;
      if (accept && !gen_padded) begin
        req     <= 1'b1;
        addr_q  <= gen_addr;
        wdata_q <= bus.oup_data;
        be_q    <= gen_be;
      end else if (bus.mem_gnt) begin
        req <= 1'b0;
      end

      case (state)
        Idle: begin
          if (start) begin
            cfg_seq    <= seq_length;
            cfg_cols   <= out_cols;
            cfg_stride <= row_stride;
            cfg_base   <= base_addr;
            cfg_tx     <= tile_count(out_cols);
            cfg_ty     <= tile_count(seq_length);
            busy       <= 1'b1;
            state      <= (seq_length == '0 || out_cols == '0) ? Drain : Run;
          end
        end
        Run: begin
          // a dropped final beat with nothing pending can finish without waiting in Drain
          if (accept && gen_last) begin
            if (gen_padded && slot_free) begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= Idle;
            end else begin
              state <= Drain;
            end
          end
        end
        Drain: begin
          if (slot_free) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= Idle;
          end
        end
        default: state <= Idle;
      endcase
    end
  end

`ifdef ITA_OUT_WRITER_STATS_EN
  logic [31:0] n_wr, n_drop, n_stall;

  always_ff @(posedge clk) begin
    if (rst || (idle && start)) begin
      n_wr    <= '0;
      n_drop  <= '0;
      n_stall <= '0;
    end else begin
      if (req && bus.mem_gnt && n_wr != '1)      n_wr    <= n_wr + 32'd1;
      if (accept && gen_padded && n_drop != '1)  n_drop  <= n_drop + 32'd1;
      if (req && !bus.mem_gnt && n_stall != '1)  n_stall <= n_stall + 32'd1;
    end
  end

  assign stat_wr    = n_wr;
  assign stat_drop  = n_drop;
  assign stat_stall = n_stall;
`else
  assign stat_wr    = '0;
  assign stat_drop  = '0;
  assign stat_stall = '0;
`endif
endmodule
`default_nettype wire
